trigger_capture: RTL

Trigger-qualified sample capture stage of the internal logic analyzer. It consumes the aligned sample stream from the sample delay stage and continuously writes it into a circular sample RAM once armed. It detects a masked-match trigger and stops after a programmed number of post-trigger samples. It then streams the whole buffer out, oldest sample first, to the host readout logic.

---
 rtl/trigger_capture.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/trigger_capture.sv
`default_nettype none
// ============================================================================
// trigger_capture : armed circular sample capture with masked-match trigger,
//                   stops after a post-trigger count, reads out oldest-first.
// Revision        : 1.0
// ============================================================================
module trigger_capture #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [DATA_WIDTH-1:0] trig_value,
    input  logic [DATA_WIDTH-1:0] trig_mask,
    input  logic [ADDR_WIDTH-1:0] post_count,
    input  logic                  arm,
    input  logic                  rd_en,
    output logic                  armed,
    output logic                  triggered,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_last
);

    localparam int                  c_DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_ALL_ONES = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] c_ONE      = ADDR_WIDTH'(1);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_PRE  = 3'd1;
    localparam logic [2:0] c_WAIT = 3'd2;
    localparam logic [2:0] c_POST = 3'd3;
    localparam logic [2:0] c_DONE = 3'd4;

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    // Shared write/read pointer: after the last write it already points at
    // the oldest sample, and no writes happen while reading out.
    logic [ADDR_WIDTH-1:0] r_ptr;
    // Counts PRE writes, then POST writes, then DONE reads.
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] r_post;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;
    logic                  r_rd_last;

    logic                  w_match;
    logic [ADDR_WIDTH-1:0] w_post_eff;
    logic                  w_pre_last;
    logic                  w_post_last;
    logic                  w_wr_en;
    logic                  w_rd_fire;

    assign w_match     = ((i_data ^ trig_value) & trig_mask) == '0;
    assign w_post_eff  = (post_count == '0) ? c_ONE : post_count;
    // DEPTH - P - 1 is the index of the final pre-trigger write.
    assign w_pre_last  = (r_cnt == (c_ALL_ONES - r_post));
    assign w_post_last = (r_cnt == (r_post - c_ONE));
    assign w_wr_en     = !arm && ((r_state == c_PRE) || (r_state == c_WAIT) ||
                                  (r_state == c_POST));
    assign w_rd_fire   = !arm && rd_en && (r_state == c_DONE);

    always_ff @(posedge clk) begin
        if (reset) r_state <= c_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (arm) begin
            w_next_state = c_PRE;
        end else begin
            case (r_state)
                c_PRE:   if (w_pre_last) w_next_state = c_WAIT;
                c_WAIT:  if (w_match) w_next_state = (r_post == c_ONE) ? c_DONE : c_POST;
                c_POST:  if (w_post_last) w_next_state = c_DONE;
                c_DONE:  if (rd_en && (r_cnt == c_ALL_ONES)) w_next_state = c_IDLE;
                default: w_next_state = c_IDLE;
            endcase
        end
    end

    always_comb begin
        armed     = 1'b0;
        triggered = 1'b0;
        done      = 1'b0;
        case (r_state)
            c_PRE, c_WAIT: armed = 1'b1;
            c_POST:        triggered = 1'b1;
            c_DONE: begin
                triggered = 1'b1;
                done      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_post     <= c_ONE;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_fire;
            r_rd_last  <= w_rd_fire && (r_cnt == c_ALL_ONES);
            if (arm) begin
                r_ptr  <= '0;
                r_cnt  <= '0;
                r_post <= w_post_eff;
            end else begin
                case (r_state)
                    c_PRE: begin
                        r_ptr <= r_ptr + c_ONE;
                        r_cnt <= w_pre_last ? '0 : r_cnt + c_ONE;
                    end
                    c_WAIT: begin
                        r_ptr <= r_ptr + c_ONE;
                        r_cnt <= (w_match && (r_post != c_ONE)) ? c_ONE : '0;
                    end
                    c_POST: begin
                        r_ptr <= r_ptr + c_ONE;
                        r_cnt <= w_post_last ? '0 : r_cnt + c_ONE;
                    end
                    c_DONE: begin
                        if (rd_en) begin
                            r_ptr <= r_ptr + c_ONE;
                            r_cnt <= r_cnt + c_ONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_ptr] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (reset)          r_rd_data <= '0;
        else if (w_rd_fire) r_rd_data <= r_mem[r_ptr];
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign rd_last  = r_rd_last;

endmodule
`default_nettype wire
